// File: rtl/bus_pkg.sv
// Shared types and constants for the single-master bus fabric.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [19:0] MEM_ADDR        = 20'h00000;
    localparam logic [19:0] PERIPH_ADDR     = 20'h01000;
    localparam int          ERR_COUNT_WIDTH = 8;

endpackage

// File: rtl/bus_fabric_if.sv
// Master-side and slave-side bus signals of the fabric.
// The fabric sits on the slave modport; the CPU/peripheral environment uses the master modport.
interface bus_fabric_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SLAVES = 2
) ();
    logic [ADDR_WIDTH-1:0]            m_addr;
    logic [DATA_WIDTH-1:0]            m_wdata;
    logic                             m_read;
    logic                             m_write;
    logic [DATA_WIDTH-1:0]            m_rdata;
    logic                             m_ready;
    logic                             m_error;
    logic [NUM_SLAVES-1:0]            s_sel;
    logic [ADDR_WIDTH-1:0]            s_addr;
    logic [DATA_WIDTH-1:0]            s_wdata;
    logic                             s_read;
    logic                             s_write;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]            s_ready;

    modport slave (
        input  m_addr, m_wdata, m_read, m_write, s_rdata, s_ready,
        output m_rdata, m_ready, m_error, s_sel, s_addr, s_wdata, s_read, s_write
    );

    modport master (
        output m_addr, m_wdata, m_read, m_write, s_rdata, s_ready,
        input  m_rdata, m_ready, m_error, s_sel, s_addr, s_wdata, s_read, s_write
    );
endinterface

// File: rtl/bus_decoder.sv
// Combinational address decoder: one-hot window select, lowest index wins on overlap.
module bus_decoder #(
    parameter int                                ADDR_WIDTH = 20,
    parameter int                                NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  hit_o
);

    always_comb begin
        sel_o = '0;
        hit_o = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit_o && ((addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                           == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                sel_o[i] = 1'b1;
                hit_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Single-master, N-slave interconnect: decode, wait-state access with timeout,
// one-cycle response and a saturating error counter.
module bus_fabric
    import bus_pkg::*;
#(
    parameter int                                ADDR_WIDTH = 20,
    parameter int                                DATA_WIDTH = 16,
    parameter int                                NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {PERIPH_ADDR, MEM_ADDR},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {20'hFFFF0, 20'hFFC00},
    parameter int                                TIMEOUT    = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    bus_fabric_if.slave                bus,
    output logic [ERR_COUNT_WIDTH-1:0] err_count
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
    logic                         wr_q, wr_d;
    logic [NUM_SLAVES-1:0]        sel_q, sel_d;
    logic [7:0]                   tmo_q, tmo_d;
    logic                         err_q, err_d;
    logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
    logic [ERR_COUNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

    logic [NUM_SLAVES-1:0]        dec_sel;
    logic                         dec_hit;
    logic [DATA_WIDTH-1:0]        sel_rdata;
    logic                         slave_rdy;

    bus_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .addr_i (bus.m_addr),
        .sel_o  (dec_sel),
        .hit_o  (dec_hit)
    );

    // Only the latched slot's ready/data are observed; other slots are don't-care.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) sel_rdata = bus.s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end
    assign slave_rdy = |(bus.s_ready & sel_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            sel_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            sel_q     <= sel_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        sel_d     = sel_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (bus.m_read ^ bus.m_write) begin
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wdata;
                    wr_d    = bus.m_write;
                    sel_d   = dec_sel;
                    tmo_d   = '0;
                    if (dec_hit) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end else if (bus.m_read & bus.m_write) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            ACCESS: begin
                if (slave_rdy) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? '0 : sel_rdata;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (err_q && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.m_ready   = (state_q == RESP);
        bus.m_error   = (state_q == RESP) && err_q;
        bus.m_rdata   = rdata_q;
        bus.s_sel     = (state_q == ACCESS) ? sel_q : '0;
        bus.s_read    = (state_q == ACCESS) && !wr_q;
        bus.s_write   = (state_q == ACCESS) && wr_q;
        bus.s_addr    = addr_q;
        bus.s_wdata   = wdata_q;
        err_count     = err_cnt_q;
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: one task per scenario with inline expected values.
module tb_bus_fabric;

    logic       clk;
    logic       reset;
    logic [7:0] err_count;
    logic [7:0] err_count2;

    bus_fabric_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .NUM_SLAVES(2)) bus ();
    bus_fabric_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .NUM_SLAVES(2)) bus2 ();

    bus_fabric dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err_count (err_count)
    );

    // Second instance with overlapping windows at 0x00000, sharing the same stimulus.
    bus_fabric #(
        .SLAVE_BASE ({20'h00000, 20'h00000}),
        .SLAVE_MASK ({20'hFF000, 20'hFFC00})
    ) dut_ovl (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus2),
        .err_count (err_count2)
    );

    assign bus2.m_addr  = bus.m_addr;
    assign bus2.m_wdata = bus.m_wdata;
    assign bus2.m_read  = bus.m_read;
    assign bus2.m_write = bus.m_write;
    assign bus2.s_rdata = bus.s_rdata;
    assign bus2.s_ready = bus.s_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int          r_lat, r_nrd, r_nwr;
    logic [15:0] r_rdata, r_swdata;
    logic [19:0] r_saddr;
    logic        r_err;
    logic [1:0]  r_sel, r_sel2;

    // Drives one request from an IDLE negedge and plays the slave: the selected slot
    // raises s_ready in its wait_n-th ACCESS cycle (wait_n=0: never); idle_rdy is held
    // on s_ready throughout. Stops at m_ready or after 40 cycles (r_lat stays -1).
    task automatic run_req(input logic rd, input logic wr, input logic [19:0] addr,
                           input logic [15:0] wd, input int wait_n, input logic [1:0] idle_rdy);
        int nstb;
        bus.m_addr = addr; bus.m_wdata = wd; bus.m_read = rd; bus.m_write = wr;
        bus.s_ready = idle_rdy;
        r_lat = -1; r_nrd = 0; r_nwr = 0; r_sel = '0; r_sel2 = '0;
        r_saddr = '0; r_swdata = '0; r_err = 1'b0; r_rdata = '0;
        nstb = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.m_ready) begin
                r_lat = k; r_rdata = bus.m_rdata; r_err = bus.m_error;
                break;
            end
            r_sel  = r_sel | bus.s_sel;
            r_sel2 = r_sel2 | bus2.s_sel;
            if (bus.s_read)  r_nrd++;
            if (bus.s_write) r_nwr++;
            if (bus.s_read || bus.s_write) begin
                nstb++;
                r_saddr = bus.s_addr; r_swdata = bus.s_wdata;
            end
            bus.s_ready = idle_rdy | ((wait_n != 0 && nstb == wait_n) ? bus.s_sel : 2'b00);
        end
        bus.m_read = 1'b0; bus.m_write = 1'b0; bus.s_ready = idle_rdy;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.m_addr = '0; bus.m_wdata = '0; bus.m_read = 1'b0; bus.m_write = 1'b0;
        bus.s_rdata = {16'hCAFE, 16'hBEEF}; bus.s_ready = '0;
        repeat (3) @(negedge clk);
        n_chk++; if ({bus.m_ready, bus.m_error, bus.s_read, bus.s_write} !== 4'b0)
            $display("FAIL rst_strobes: got %b want 0000", {bus.m_ready, bus.m_error, bus.s_read, bus.s_write}); else n_pass++;
        n_chk++; if ({bus.m_rdata, bus.s_wdata, bus.s_addr, bus.s_sel} !== 54'h0)
            $display("FAIL rst_data: got %h want 0", {bus.m_rdata, bus.s_wdata, bus.s_addr, bus.s_sel}); else n_pass++;
        n_chk++; if (err_count !== 8'd0) $display("FAIL rst_errcnt: got %0d want 0", err_count); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_wait_read();
        run_req(1'b1, 1'b0, 20'h00010, 16'h0000, 0, 2'b01);
        n_chk++; if (r_lat !== 2) $display("FAIL zw_latency: got %0d want 2", r_lat); else n_pass++;
        n_chk++; if (r_rdata !== 16'hBEEF) $display("FAIL zw_rdata: got %h want beef", r_rdata); else n_pass++;
        n_chk++; if (r_err !== 1'b0) $display("FAIL zw_error: got %b want 0", r_err); else n_pass++;
        n_chk++; if (r_nrd !== 1 || r_nwr !== 0) $display("FAIL zw_strobes: got rd=%0d wr=%0d want rd=1 wr=0", r_nrd, r_nwr); else n_pass++;
        n_chk++; if (r_sel !== 2'b01) $display("FAIL zw_sel: got %b want 01", r_sel); else n_pass++;
        n_chk++; if (r_saddr !== 20'h00010) $display("FAIL zw_saddr: got %h want 00010", r_saddr); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.m_ready !== 1'b0) $display("FAIL zw_ready_pulse: got %b want 0", bus.m_ready); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.m_rdata !== 16'hBEEF) $display("FAIL zw_rdata_hold: got %h want beef", bus.m_rdata); else n_pass++;
    endtask

    task automatic test_wait_write();
        run_req(1'b0, 1'b1, 20'h01004, 16'h1234, 3, 2'b00);
        n_chk++; if (r_lat !== 4) $display("FAIL ww_latency: got %0d want 4", r_lat); else n_pass++;
        n_chk++; if (r_nwr !== 3 || r_nrd !== 0) $display("FAIL ww_strobes: got wr=%0d rd=%0d want wr=3 rd=0", r_nwr, r_nrd); else n_pass++;
        n_chk++; if (r_swdata !== 16'h1234) $display("FAIL ww_wdata: got %h want 1234", r_swdata); else n_pass++;
        n_chk++; if (r_saddr !== 20'h01004) $display("FAIL ww_saddr: got %h want 01004", r_saddr); else n_pass++;
        n_chk++; if (r_sel !== 2'b10) $display("FAIL ww_sel: got %b want 10", r_sel); else n_pass++;
        n_chk++; if (r_err !== 1'b0 || r_rdata !== 16'h0) $display("FAIL ww_resp: got err=%b rdata=%h want err=0 rdata=0000", r_err, r_rdata); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_unmapped_timeout();
        run_req(1'b1, 1'b0, 20'h80000, 16'h0000, 0, 2'b11);
        n_chk++; if (r_lat !== 1) $display("FAIL um_latency: got %0d want 1", r_lat); else n_pass++;
        n_chk++; if (r_err !== 1'b1 || r_rdata !== 16'h0) $display("FAIL um_resp: got err=%b rdata=%h want err=1 rdata=0000", r_err, r_rdata); else n_pass++;
        n_chk++; if (r_nrd !== 0 || r_nwr !== 0) $display("FAIL um_strobes: got rd=%0d wr=%0d want 0", r_nrd, r_nwr); else n_pass++;
        @(negedge clk);
        n_chk++; if (err_count !== 8'd1) $display("FAIL um_errcnt: got %0d want 1", err_count); else n_pass++;
        // slot0 never ready; slot1 ready stuck high but unselected
        run_req(1'b1, 1'b0, 20'h00010, 16'h0000, 0, 2'b10);
        n_chk++; if (r_lat !== 16) $display("FAIL to_latency: got %0d want 16", r_lat); else n_pass++;
        n_chk++; if (r_nrd !== 15) $display("FAIL to_access_cycles: got %0d want 15", r_nrd); else n_pass++;
        n_chk++; if (r_err !== 1'b1 || r_rdata !== 16'h0) $display("FAIL to_resp: got err=%b rdata=%h want err=1 rdata=0000", r_err, r_rdata); else n_pass++;
        @(negedge clk);
        n_chk++; if (err_count !== 8'd2) $display("FAIL to_errcnt: got %0d want 2", err_count); else n_pass++;
    endtask

    task automatic test_illegal_and_saturation();
        run_req(1'b1, 1'b1, 20'h00010, 16'h5555, 0, 2'b01);
        n_chk++; if (r_lat !== 1 || r_err !== 1'b1) $display("FAIL ill_resp: got lat=%0d err=%b want lat=1 err=1", r_lat, r_err); else n_pass++;
        n_chk++; if (r_nrd !== 0 || r_nwr !== 0) $display("FAIL ill_strobes: got rd=%0d wr=%0d want 0", r_nrd, r_nwr); else n_pass++;
        @(negedge clk);
        n_chk++; if (err_count !== 8'd3) $display("FAIL ill_errcnt: got %0d want 3", err_count); else n_pass++;
        for (int i = 0; i < 300; i++) begin
            run_req(1'b1, 1'b0, 20'h80000, 16'h0000, 0, 2'b00);
            @(negedge clk);
            if (i == 251) begin
                n_chk++; if (err_count !== 8'd255) $display("FAIL sat_reach: got %0d want 255", err_count); else n_pass++;
            end
        end
        n_chk++; if (err_count !== 8'd255) $display("FAIL sat_hold: got %0d want 255", err_count); else n_pass++;
    endtask

    task automatic test_overlap();
        run_req(1'b1, 1'b0, 20'h00010, 16'h0000, 0, 2'b11);
        n_chk++; if (r_sel2 !== 2'b01) $display("FAIL ovl_sel: got %b want 01", r_sel2); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        logic seen;
        bus.m_addr = 20'h00010; bus.m_read = 1'b1; bus.s_ready = 2'b00;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.s_read !== 1'b1) $display("FAIL rm_in_access: got %b want 1", bus.s_read); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_chk++; if ({bus.s_read, bus.s_sel, bus.m_ready} !== 4'b0) $display("FAIL rm_async_out: got %b want 0000", {bus.s_read, bus.s_sel, bus.m_ready}); else n_pass++;
        n_chk++; if (bus.s_addr !== 20'h0) $display("FAIL rm_async_addr: got %h want 00000", bus.s_addr); else n_pass++;
        n_chk++; if (err_count !== 8'd0 || err_count2 !== 8'd0) $display("FAIL rm_errcnt: got %0d/%0d want 0/0", err_count, err_count2); else n_pass++;
        bus.m_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.m_ready) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL rm_no_ready: got %b want 0", seen); else n_pass++;
        run_req(1'b1, 1'b0, 20'h00010, 16'h0000, 0, 2'b01);
        n_chk++; if (r_lat !== 2 || r_rdata !== 16'hBEEF) $display("FAIL rm_after: got lat=%0d rdata=%h want lat=2 rdata=beef", r_lat, r_rdata); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int npulse, first, second;
        npulse = 0; first = -1; second = -1;
        bus.m_addr = 20'h00020; bus.m_read = 1'b1; bus.s_ready = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (bus.m_ready) begin
                npulse++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        bus.m_read = 1'b0;
        n_chk++; if (npulse !== 3) $display("FAIL b2b_count: got %0d want 3", npulse); else n_pass++;
        n_chk++; if (first !== 2 || second !== 5) $display("FAIL b2b_spacing: got %0d,%0d want 2,5", first, second); else n_pass++;
        n_chk++; if (bus.m_rdata !== 16'hBEEF) $display("FAIL b2b_rdata: got %h want beef", bus.m_rdata); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_unmapped_timeout();
        test_illegal_and_saturation();
        test_overlap();
        test_reset_mid_access();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised single-master, N-slave memory-mapped interconnect between `cpu` and its memory and peripherals.
- Replaces the current point-to-point `cpu`/`data_memory` wiring.
- Decodes the address to one slave window and sequences the access through a small FSM with a wait-state handshake.
- Returns an error response for unmapped addresses, slave timeouts and illegal strobes; keeps a saturating error counter for board debug (LEDR).

Parameters:
- ADDR_WIDTH, 20, address bus width.
- DATA_WIDTH, 16, data bus width.
- NUM_SLAVES, 2, number of slave windows (1..8).
- SLAVE_BASE, {20'h01000,20'h00000}, packed NUM_SLAVES*ADDR_WIDTH base addresses; slot i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLAVE_MASK, {20'hFFFF0,20'hFFC00}, packed match masks; slot i hits when (m_addr & mask_i) == base_i.
- TIMEOUT, 15, max ACCESS cycles before error (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m_addr  in  ADDR_WIDTH  master address
- m_wdata  in  DATA_WIDTH  master write data
- m_read  in  1  master read request
- m_write  in  1  master write request
- m_rdata  out  DATA_WIDTH  read data, valid with m_ready
- m_ready  out  1  one-cycle completion pulse
- m_error  out  1  qualifies m_ready: access failed
- s_sel  out  NUM_SLAVES  one-hot slave select
- s_addr  out  ADDR_WIDTH  latched address (full, not offset)
- s_wdata  out  DATA_WIDTH  latched write data
- s_read  out  1  read strobe to selected slave
- s_write  out  1  write strobe to selected slave
- s_rdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
- s_ready  in  NUM_SLAVES  per-slave completion
- err_count  out  8  saturating error counter

Behaviour:
- Reset (reset=0, async):
  - FSM to IDLE.
  - All outputs 0, including err_count.
  - Any in-flight access is abandoned silently; no m_ready is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If m_read^m_write: latch m_addr, m_wdata and the direction, decode, go ACCESS.
  - If m_read&m_write: go RESP with error.
  - If no strobe: stay in IDLE.
- Decode:
  - Lowest-index matching slot wins on overlap.
  - No match: go directly to RESP with error; no slave strobe is ever asserted.
- ACCESS:
  - s_sel one-hot, s_read or s_write held high, s_addr/s_wdata stable.
  - Timeout counter starts at 0 and increments each cycle.
  - If s_ready[sel]=1: capture s_rdata[sel] (reads only), go RESP.
  - Otherwise, if counter == TIMEOUT-1: go RESP with error.
  - s_ready of unselected slots is ignored.
- RESP:
  - m_ready=1 for exactly one cycle; m_error as determined above.
  - s_* strobes and s_sel are 0.
  - Go IDLE.
- m_rdata:
  - Holds the captured value until the next RESP.
  - Forced to 0 on an error or write response.
- Handshake rules:
  - Master holds its strobes and inputs stable until m_ready.
  - Master drops its strobes in the cycle after m_ready.
  - A request still present in IDLE is treated as new.
- Minimum latency:
  - Request sampled at edge 0, ACCESS during cycle 1.
  - Zero-wait slave asserts s_ready combinationally in cycle 1.
  - m_ready during cycle 2, so 2 cycles per access.
  - Next request accepted at the edge ending the IDLE cycle.
- err_count increments on every error RESP cycle and saturates at 255.
- Unlatched master inputs changing during ACCESS have no effect.

Decomposition:
- Shared package `bus_pkg`:
  - FSM state encoding (2-bit).
  - Default window constants MEM_ADDR=20'h00000 and PERIPH_ADDR=20'h01000.
  - ERR_COUNT_WIDTH=8.
- One natural sub-module: `bus_decoder`, combinational address-to-one-hot with priority and a `hit` flag, reused later for a second master.
- FSM, timeout counter and response registers stay in `bus_fabric`.

Test Plan:
- Zero-wait read: slot0 s_ready tied 1, s_rdata0=16'hBEEF, read 20'h00010 -> s_sel=2'b01 one cycle; m_ready at request+2; m_rdata=16'hBEEF, m_error=0.
- Wait-state write: slot1 asserts s_ready after 3 ACCESS cycles, write 16'h1234 to 20'h01004 -> s_write high exactly 3 cycles with s_wdata=16'h1234; m_ready at request+4; m_error=0.
- Unmapped plus timeout:
  - read 20'h80000 -> no s_read ever, m_ready at request+1 with m_error=1, m_rdata=0, err_count=1;
  - slot0 s_ready stuck 0 -> m_error after 15 ACCESS cycles, err_count=2.
- Illegal strobe and saturation:
  - m_read=m_write=1 -> error response;
  - 300 consecutive errors -> err_count stays 255.
- Overlap priority, reset and back-to-back:
  - windows overlap at 20'h00000 -> only s_sel[0] asserted;
  - reset pulsed low mid-ACCESS -> all outputs 0 asynchronously, no m_ready, next request completes normally;
  - back-to-back reads -> one access per 3 cycles.
